// File: rtl/alu_pkg.sv
// Shared ALU types: opcode encoding and datapath width.
package alu_pkg;

  localparam int ALU_WIDTH = 64;

  typedef enum logic [1:0] {
    ALU_ADD = 2'b00,
    ALU_SUB = 2'b01,
    ALU_AND = 2'b10,
    ALU_XOR = 2'b11
  } alu_op_t;

endpackage

// File: rtl/adder_64.sv
// Carry-lookahead adder built from 4-bit groups; the groups are chained
// through their carries. Used for both add (cin=0) and subtract
// (b pre-inverted, cin=1). ovf compares the carry into and out of the MSB.
module adder_64
  import alu_pkg::*;
#(
  parameter int WIDTH = ALU_WIDTH
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  logic [WIDTH-1:0] w_g;
  logic [WIDTH-1:0] w_p;
  logic [WIDTH:0]   w_c;

  assign w_g    = a & b;
  assign w_p    = a ^ b;
  assign w_c[0] = cin;

  // Each group resolves its four carries directly from the group carry-in.
  // WIDTH is expected to be a multiple of 4.
  genvar gi;
  generate
    for (gi = 0; gi < WIDTH / 4; gi++) begin : g_cla
      localparam int B = gi * 4;
      assign w_c[B+1] = w_g[B]
                      | (w_p[B] & w_c[B]);
      assign w_c[B+2] = w_g[B+1]
                      | (w_p[B+1] & w_g[B])
                      | (w_p[B+1] & w_p[B] & w_c[B]);
      assign w_c[B+3] = w_g[B+2]
                      | (w_p[B+2] & w_g[B+1])
                      | (w_p[B+2] & w_p[B+1] & w_g[B])
                      | (w_p[B+2] & w_p[B+1] & w_p[B] & w_c[B]);
      assign w_c[B+4] = w_g[B+3]
                      | (w_p[B+3] & w_g[B+2])
                      | (w_p[B+3] & w_p[B+2] & w_g[B+1])
                      | (w_p[B+3] & w_p[B+2] & w_p[B+1] & w_g[B])
                      | (w_p[B+3] & w_p[B+2] & w_p[B+1] & w_p[B] & w_c[B]);
    end
  endgenerate

  assign sum  = w_p ^ w_c[WIDTH-1:0];
  assign cout = w_c[WIDTH];
  assign ovf  = w_c[WIDTH] ^ w_c[WIDTH-1];

endmodule

// File: rtl/alu_64.sv
// Four-function registered ALU (add, sub, and, xor) with signed-overflow
// and zero flags. One-cycle latency, a new operation accepted every cycle.
module alu_64
  import alu_pkg::*;
#(
  parameter int WIDTH = ALU_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [1:0]       opcode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] res,
  output logic             overflow,
  output logic             zero
);

  alu_op_t          w_op;
  logic             w_is_sub;
  logic [WIDTH-1:0] w_b_op;
  logic [WIDTH-1:0] w_sum;
  logic             w_add_ovf;
  logic [WIDTH-1:0] w_res;
  logic             w_ovf;

  logic [WIDTH-1:0] r_res;
  logic             r_ovf;
  logic             r_zero;

  assign w_op     = alu_op_t'(opcode);
  assign w_is_sub = (w_op == ALU_SUB);
  // Subtract reuses the adder as a + ~b + 1.
  assign w_b_op   = w_is_sub ? ~b : b;

  // Carry out of the MSB is dropped: results wrap modulo 2^WIDTH.
  adder_64 #(.WIDTH(WIDTH)) u_adder (
    .a    (a),
    .b    (w_b_op),
    .cin  (w_is_sub),
    .sum  (w_sum),
    .cout (),
    .ovf  (w_add_ovf)
  );

  // Result/overflow select; logic ops never report overflow.
  always_comb begin
    w_res = '0;
    w_ovf = 1'b0;
    case (w_op)
      ALU_ADD, ALU_SUB: begin
        w_res = w_sum;
        w_ovf = w_add_ovf;
      end
      ALU_AND: w_res = a & b;
      ALU_XOR: w_res = a ^ b;
      default: begin
        w_res = '0;
        w_ovf = 1'b0;
      end
    endcase
  end

  // Output registers; zero is derived from the same next result as res.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_res  <= '0;
      r_ovf  <= 1'b0;
      r_zero <= 1'b0;
    end else begin
      r_res  <= w_res;
      r_ovf  <= w_ovf;
      r_zero <= (w_res == '0);
    end
  end

  assign res      = r_res;
  assign overflow = r_ovf;
  assign zero     = r_zero;

endmodule

// File: tb/tb_alu_64.sv
// Self-checking bench for alu_64: directed corner cases, back-to-back
// pipelining and a randomized run against a signed-arithmetic model.
module tb_alu_64;
  import alu_pkg::*;

  logic        clk;
  logic        rst_n;
  logic [1:0]  opcode;
  logic [63:0] a, b;
  logic [63:0] res;
  logic        overflow, zero;

  int n_chk  = 0;
  int n_pass = 0;

  alu_64 dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .opcode   (opcode),
    .a        (a),
    .b        (b),
    .res      (res),
    .overflow (overflow),
    .zero     (zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%016h want 0x%016h", tag, obs, exp);
  endtask

  // Reference: sign-extend to 65 bits, do the arithmetic exactly, and
  // flag overflow when the exact result does not fit in 64 signed bits.
  function automatic logic [65:0] model(input logic [1:0] op, input logic [63:0] x, input logic [63:0] y);
    logic signed [64:0] wide;
    logic [63:0] r;
    logic        o;
    wide = '0;
    o    = 1'b0;
    case (op)
      2'b00: begin wide = $signed({x[63], x}) + $signed({y[63], y}); r = wide[63:0]; o = (wide[64] != wide[63]); end
      2'b01: begin wide = $signed({x[63], x}) - $signed({y[63], y}); r = wide[63:0]; o = (wide[64] != wide[63]); end
      2'b10: r = x & y;
      default: r = x ^ y;
    endcase
    return {o, (r == 64'd0), r};
  endfunction

  // Drive one operation at the falling edge, check it just after the rising edge.
  task automatic run_op(input string tag, input logic [1:0] op, input logic [63:0] x, input logic [63:0] y,
                        input logic [63:0] er, input logic eo, input logic ez);
    @(negedge clk);
    opcode = op; a = x; b = y;
    @(posedge clk); #1;
    chk({tag, ".res"}, res, er);
    chk({tag, ".ovf"}, {63'd0, overflow}, {63'd0, eo});
    chk({tag, ".zero"}, {63'd0, zero}, {63'd0, ez});
  endtask

  function automatic logic [63:0] pick();
    logic [63:0] v;
    case ($urandom_range(0, 7))
      0: v = 64'h7FFF_FFFF_FFFF_FFFF;
      1: v = 64'h8000_0000_0000_0000;
      2: v = 64'hFFFF_FFFF_FFFF_FFFF;
      3: v = 64'd0;
      4: v = 64'(signed'($urandom_range(0, 4)) - 2);
      default: v = {$urandom, $urandom};
    endcase
    return v;
  endfunction

  initial begin
    logic [65:0] m;
    logic [63:0] ra, rb;
    logic [1:0]  rop;
    rst_n = 1'b0; opcode = 2'b00; a = '0; b = '0;
    #12;
    chk("rst.res", res, 64'd0);
    chk("rst.ovf", {63'd0, overflow}, 64'd0);
    chk("rst.zero", {63'd0, zero}, 64'd0);
    @(negedge clk); rst_n = 1'b1;

    // Mid-cycle asynchronous reset over a live result.
    run_op("pre", ALU_ADD, 64'h1234, 64'd0, 64'h1234, 1'b0, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    chk("arst.res", res, 64'd0);
    chk("arst.zero", {63'd0, zero}, 64'd0);
    @(posedge clk); #1;
    chk("arst.hold", res, 64'd0);
    @(negedge clk); rst_n = 1'b1;
    run_op("add5_7", ALU_ADD, 64'd5, 64'd7, 64'd12, 1'b0, 1'b0);

    // Directed corners.
    run_op("add_ovf",  ALU_ADD, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 64'h8000_0000_0000_0000, 1'b1, 1'b0);
    run_op("add_wrap", ALU_ADD, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'd0, 1'b0, 1'b1);
    run_op("sub_eq",   ALU_SUB, 64'd10, 64'd10, 64'd0, 1'b0, 1'b1);
    run_op("sub_ovf",  ALU_SUB, 64'h8000_0000_0000_0000, 64'd1, 64'h7FFF_FFFF_FFFF_FFFF, 1'b1, 1'b0);
    run_op("sub_neg",  ALU_SUB, 64'd3, 64'd5, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 1'b0);
    run_op("and",      ALU_AND, 64'hF0F0_F0F0_F0F0_F0F0, 64'h0F0F_0F0F_0F0F_0F0F, 64'd0, 1'b0, 1'b1);
    run_op("xor",      ALU_XOR, 64'hAAAA_AAAA_AAAA_AAAA, 64'h5555_5555_5555_5555, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b0);

    // Back-to-back: overflowing add followed by ops that must not inherit it.
    run_op("pipe_add", ALU_ADD, 64'h7FFF_FFFF_FFFF_FFFF, 64'h7FFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFE, 1'b1, 1'b0);
    run_op("pipe_sub", ALU_SUB, 64'd100, 64'd1, 64'd99, 1'b0, 1'b0);
    run_op("pipe_and", ALU_AND, 64'hFFFF_0000_FFFF_0000, 64'hFF00_FF00_FF00_FF00, 64'hFF00_0000_FF00_0000, 1'b0, 1'b0);
    run_op("pipe_xor", ALU_XOR, 64'h1234_5678_9ABC_DEF0, 64'h1234_5678_9ABC_DEF0, 64'd0, 1'b0, 1'b1);

    // Randomized, one op per cycle.
    for (int i = 0; i < 10000; i++) begin
      rop = 2'($urandom_range(0, 3));
      ra  = pick();
      rb  = ($urandom_range(0, 15) == 0) ? ra : pick();
      m   = model(rop, ra, rb);
      run_op("rnd", rop, ra, rb, m[63:0], m[65], m[64]);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/alu_64.md
Name: alu_64

Overview:
- 64-bit, four-function integer ALU used by the Y86-64 SEQ execute stage: add, subtract, bitwise AND, bitwise XOR.
- Produces a result plus signed-overflow and zero flags; the execute stage derives the ZF/SF/OF condition codes from these.
- Outputs are registered: one-cycle latency, one clock, asynchronous active-low reset.

Parameters:
- WIDTH, 64, operand/result width in bits. All behaviour is specified at 64; other widths scale identically.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- opcode  input  2  operation select: 00 add, 01 sub, 10 and, 11 xor.
- a  input  WIDTH  operand A, two's-complement signed.
- b  input  WIDTH  operand B, two's-complement signed.
- res  output  WIDTH  registered result.
- overflow  output  1  registered signed-overflow flag.
- zero  output  1  registered zero flag, high when res == 0.

Behaviour:
- Reset:
  - rst_n low asynchronously forces res=0, overflow=0, zero=0, independent of clk.
  - Outputs hold these values while rst_n is low.
  - The first capture occurs on the first rising clk edge with rst_n high.
- Latency: opcode, a and b are sampled on each rising edge; the corresponding res/overflow/zero are valid after that edge and held until the next edge.
- Throughput: a new operation every cycle. No handshake, no enable, no stall.
- Add (00): res = (a + b) mod 2^64.
  - overflow = (a[63] == b[63]) && (sum[63] != a[63]).
- Sub (01): res = (a - b) mod 2^64, computed as a + ~b + 1 on the shared adder.
  - overflow = (a[63] != b[63]) && (diff[63] != a[63]).
- And (10): res = a & b; overflow = 0.
- Xor (11): res = a ^ b; overflow = 0.
- Zero: zero = (next res == 0), for every opcode, computed from the same-cycle result so it is always consistent with res.
- Wrap-around: carry out of bit 63 is discarded and not exported. Examples:
  - 0xFFFF_FFFF_FFFF_FFFF + 1 = 0, zero=1, overflow=0.
  - 0x7FFF_FFFF_FFFF_FFFF + 1 = 0x8000_0000_0000_0000, overflow=1.
- Sign: not a separate output; consumers use res[63].
- Reset asserted mid-stream: the in-flight result is discarded and outputs go to zero immediately. After deassertion, the first captured operation is the one presented at the next rising edge.
- X-safety: every opcode value is decoded; no latches; a full combinational case selects the next state.

Decomposition:
- Shared package alu_pkg:
  - typedef alu_op_t (2-bit) with constants ALU_ADD=2'b00, ALU_SUB=2'b01, ALU_AND=2'b10, ALU_XOR=2'b11.
  - localparam ALU_WIDTH=64.
- One natural sub-module, adder_64:
  - Ports: a, b, cin, sum, cout, ovf.
  - Performs both add (cin=0) and subtract (b inverted, cin=1).
  - Built as a chain of 1-bit full adders or 4-bit carry-lookahead groups.
  - ovf is computed from carry-in vs carry-out of bit 63.
- The top level holds the operand mux, the logic ops, the zero-detect reduction, the result mux and the output registers.

Test Plan:
- Reset: drive rst_n=0 mid-cycle with prior res=0x1234 -> res=0, overflow=0, zero=0 immediately, without waiting for a clock edge. Release, then apply add 5+7 -> res=12 after the next edge.
- Add: a=0x7FFF_FFFF_FFFF_FFFF, b=1 -> res=0x8000_0000_0000_0000, overflow=1, zero=0. Then a=-1, b=1 -> res=0, overflow=0, zero=1.
- Sub: a=10, b=10 -> res=0, zero=1, overflow=0. Then a=0x8000_0000_0000_0000, b=1 -> res=0x7FFF_FFFF_FFFF_FFFF, overflow=1. Then a=3, b=5 -> res=0xFFFF_FFFF_FFFF_FFFE, overflow=0.
- Logic:
  - and 0xF0F0_F0F0_F0F0_F0F0 & 0x0F0F_0F0F_0F0F_0F0F -> res=0, zero=1, overflow=0.
  - xor 0xAAAA_AAAA_AAAA_AAAA ^ 0x5555_5555_5555_5555 -> res=0xFFFF_FFFF_FFFF_FFFF, zero=0, overflow=0.
- Pipelining: change opcode/operands on every edge through add, sub, and, xor. Each result appears exactly one edge later, and no sticky overflow carries over from a prior add.
- Randomized: 10k random (opcode, a, b) checked against a reference model for res, overflow and zero, with one-cycle alignment.
